// File: rtl/saph_pixel_writer.sv
// Framebuffer write stage: clips rasterized pixels, packs the ARGB tint into the
// configured pixel format and issues one aligned, byte-masked 32-bit write per pixel.

package saph_types;

  typedef struct packed {
    logic [4:0] pos;
    logic [2:0] width;  // channel width minus one
  } chan_t;

  typedef struct packed {
    logic [1:0] cat;
    logic [4:0] size;   // bits per pixel minus one
    chan_t      a;
    chan_t      r;
    chan_t      g;
    chan_t      b;
  } pixfmt;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic        [15:0] z;
    logic        [15:0] u;
    logic        [15:0] v;
    logic        [31:0] col;  // {a, r, g, b}
  } pixel;

endpackage

module saph_pixel_writer
  import saph_types::*;
#(
  parameter int ADDR_W     = 32,
  parameter int CLIP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  pixel                  in_pix,
  input  pixfmt                 cfg_fmt,
  input  logic [ADDR_W-1:0]     cfg_base,
  input  logic [15:0]           cfg_stride,
  input  logic [15:0]           cfg_width,
  input  logic [15:0]           cfg_height,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  output logic                  busy,
  output logic [31:0]           cnt_written,
  output logic [CLIP_CNT_W-1:0] cnt_clipped
);

  // log2 of bytes per pixel: 0 -> 1 byte, 1 -> 2 bytes, 2 -> 4 bytes
  function automatic logic [1:0] bpp_lg(input logic [4:0] size);
    if (size < 5'd8)       return 2'd0;
    else if (size < 5'd16) return 2'd1;
    else                   return 2'd2;
  endfunction

  // Top (width+1) bits of the 8-bit channel, placed at the channel's bit position.
  function automatic logic [31:0] chan_bits(input chan_t ch, input logic [7:0] c);
    return 32'(c >> (3'd7 - ch.width)) << ch.pos;
  endfunction

  function automatic logic [31:0] pack_col(input pixfmt f, input logic [31:0] col,
                                           input logic [1:0] lg);
    logic [31:0] p;
    p = chan_bits(f.a, col[31:24]) | chan_bits(f.r, col[23:16])
      | chan_bits(f.g, col[15:8])  | chan_bits(f.b, col[7:0]);
    case (lg)
      2'd0:    p &= 32'h0000_00FF;
      2'd1:    p &= 32'h0000_FFFF;
      default: ;
    endcase
    return p;
  endfunction

  logic        s1_valid, s1_drop;
  logic [1:0]  s1_lg;
  logic [31:0] s1_off, s1_data;
  logic        s2_valid, s2_drop;
  logic        s1_adv, s2_adv;

  logic [1:0]  in_lg;
  logic        in_clip;
  logic [31:0] in_off, in_data;

  always_comb begin
    in_lg   = bpp_lg(cfg_fmt.size);
    // Negative coordinates are caught by the sign bit, so the range checks can be unsigned.
    in_clip = in_pix.x[15] | in_pix.y[15]
            | ($unsigned(in_pix.x) >= cfg_width) | ($unsigned(in_pix.y) >= cfg_height);
    in_off  = ({16'b0, $unsigned(in_pix.y)} * {16'b0, cfg_stride})
            + ({16'b0, $unsigned(in_pix.x)} << in_lg);
    in_data = pack_col(cfg_fmt, in_pix.col, in_lg);
  end

  logic [ADDR_W-1:0] s1_addr;
  logic [1:0]        s1_lane;
  logic              s1_misaligned;
  logic [3:0]        s1_strb;
  logic [31:0]       s1_wdata;

  always_comb begin
    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    s1_strb       = 4'b1111;
    s1_misaligned = 1'b0;
    s1_addr       = cfg_base + ADDR_W'(s1_off);
    s1_lane       = s1_addr[1:0];
    case (s1_lg)
      2'd0:    s1_strb = 4'b0001;
      2'd1: begin
        s1_strb       = 4'b0011;
        s1_misaligned = s1_lane[0];
      end
      default: s1_misaligned = (s1_lane != 2'd0);
    endcase
    s1_strb  = s1_strb << s1_lane;
    s1_wdata = s1_data << {s1_lane, 3'b000};
  end

  // Dropped pixels never stall: they leave S2 on the cycle after they arrive.
  assign s2_adv    = !s2_valid || mem_ready || s2_drop;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign mem_valid = s2_valid && !s2_drop;
  assign busy      = s1_valid || s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: datapath registers are reset as well because they drive module outputs directly.
      s1_valid    <= 1'b0;
      s1_drop     <= 1'b0;
      s1_lg       <= 2'd0;
      s1_off      <= '0;
      s1_data     <= '0;
      s2_valid    <= 1'b0;
      s2_drop     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      cnt_written <= '0;
      cnt_clipped <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_drop <= in_clip;
          s1_lg   <= in_lg;
          s1_off  <= in_off;
          s1_data <= in_data;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_drop   <= s1_drop || s1_misaligned;
          mem_addr  <= {s1_addr[ADDR_W-1:2], 2'b00};
          mem_wdata <= s1_wdata;
          mem_wstrb <= s1_strb;
        end
      end
      if (mem_valid && mem_ready)
        cnt_written <= cnt_written + 32'd1;
      if (s2_valid && s2_drop && (cnt_clipped != '1))
        cnt_clipped <= cnt_clipped + CLIP_CNT_W'(1);
    end
  end

  // Depth, texture coordinates and format category are carried on the bus but not used here.
  logic unused_fields;
  assign unused_fields = ^{in_pix.z, in_pix.u, in_pix.v, cfg_fmt.cat};

endmodule

// File: tb/tb_saph_pixel_writer.sv
// Scoreboard bench for saph_pixel_writer: directed format/clip/backpressure/reset cases
// plus randomized pixels checked against an arithmetic reference model.

module tb_saph_pixel_writer;
  import saph_types::*;

  localparam int ADDR_W     = 32;
  localparam int CLIP_CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  pixel                  in_pix;
  pixfmt                 cfg_fmt;
  logic [ADDR_W-1:0]     cfg_base;
  logic [15:0]           cfg_stride, cfg_width, cfg_height;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_W-1:0]     mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  busy;
  logic [31:0]           cnt_written;
  logic [CLIP_CNT_W-1:0] cnt_clipped;

  saph_pixel_writer #(.ADDR_W(ADDR_W), .CLIP_CNT_W(CLIP_CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .cfg_fmt(cfg_fmt), .cfg_base(cfg_base), .cfg_stride(cfg_stride),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .busy(busy), .cnt_written(cnt_written), .cnt_clipped(cnt_clipped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail = 0;
  int  exp_written = 0;
  int  exp_clipped = 0;
  int  acc_count = 0;
  int  rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  // Reference model: plain integer arithmetic on the format rules.
  function automatic void model(input pixel p, output bit drop, output wr_t w);
    int     bpp, lane;
    longint off, addr, packed_v, val, field;
    chan_t  c;
    bpp  = (cfg_fmt.size < 8) ? 1 : (cfg_fmt.size < 16) ? 2 : 4;
    drop = ($signed(p.x) < 0) || ($signed(p.y) < 0) ||
           (int'($signed(p.x)) >= int'(cfg_width)) || (int'($signed(p.y)) >= int'(cfg_height));
    off  = longint'($signed(p.y)) * longint'(cfg_stride) + longint'($signed(p.x)) * bpp;
    addr = (longint'(cfg_base) + off) & 64'hFFFF_FFFF;
    lane = int'(addr % 4);
    if (lane % bpp != 0) drop = 1'b1;
    packed_v = 0;
    for (int ch = 0; ch < 4; ch++) begin
      case (ch)
        0:       c = cfg_fmt.b;
        1:       c = cfg_fmt.g;
        2:       c = cfg_fmt.r;
        default: c = cfg_fmt.a;
      endcase
      val      = longint'((p.col >> (8 * ch)) & 32'hFF);
      field    = val >> (8 - (int'(c.width) + 1));
      packed_v = packed_v | (field << c.pos);
    end
    packed_v = packed_v & ((64'd1 << (8 * bpp)) - 1);
    w.data = 32'((packed_v << (8 * lane)) & 64'hFFFF_FFFF);
    w.strb = 4'(((1 << bpp) - 1) << lane);
    w.addr = 32'(addr - lane);
  endfunction

  function automatic pixel mk_pix(input int x, input int y, input logic [31:0] col);
    pixel p;
    p.x   = 16'(x);
    p.y   = 16'(y);
    p.z   = 16'($urandom);
    p.u   = 16'($urandom);
    p.v   = 16'($urandom);
    p.col = col;
    return p;
  endfunction

  // Offer one pixel; the expectation is queued on the cycle it is accepted.
  task automatic send(input pixel p, input bit literal, input wr_t lit, output int waits);
    bit  drop;
    wr_t w;
    in_pix   = p;
    in_valid = 1'b1;
    waits    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 500) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: in_ready stuck at 0 for %0d cycles", waits);
        finish_run();
      end
    end
    if (literal) begin
      exp_q.push_back(lit);
      exp_written++;
    end else begin
      model(p, drop, w);
      if (drop) exp_clipped++;
      else begin
        exp_q.push_back(w);
        exp_written++;
      end
    end
    acc_count++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input pixel p);
    wr_t dummy;
    int  waits;
    dummy = '{32'h0, 32'h0, 4'h0};
    send(p, 1'b0, dummy, waits);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((busy || exp_q.size() != 0) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = ($urandom_range(3) != 0);
      default: mem_ready = 1'b0;
    endcase
  end

  // Monitor: checks every handshake against the scoreboard and stability under stall.
  bit          hold_v = 1'b0;
  logic [31:0] hold_addr, hold_data;
  logic [3:0]  hold_strb;

  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("stall_valid", 32'(mem_valid), 32'd1);
        check("stall_addr", mem_addr, hold_addr);
        check("stall_data", mem_wdata, hold_data);
        check("stall_strb", 32'(mem_wstrb), 32'(hold_strb));
      end
      if (mem_valid && mem_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h strb %b, nothing expected",
                   mem_addr, mem_wdata, mem_wstrb);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_wdata, e.data);
          check("wr_strb", 32'(mem_wstrb), 32'(e.strb));
        end
      end
      hold_v    = mem_valid && !mem_ready;
      hold_addr = mem_addr;
      hold_data = mem_wdata;
      hold_strb = mem_wstrb;
    end
  end

  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_run();
  end

  function automatic pixfmt fmt_of(input int size, input int ap, input int aw, input int rp,
                                   input int rw, input int gp, input int gw, input int bp,
                                   input int bw);
    pixfmt f;
    f.cat  = 2'($urandom);
    f.size = 5'(size);
    f.a    = '{5'(ap), 3'(aw)};
    f.r    = '{5'(rp), 3'(rw)};
    f.g    = '{5'(gp), 3'(gw)};
    f.b    = '{5'(bp), 3'(bw)};
    return f;
  endfunction

  initial begin
    int  waits;
    int  acc0;
    wr_t lit;

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_pix     = '0;
    mem_ready  = 1'b1;
    cfg_fmt    = fmt_of(15, 16, 0, 11, 4, 5, 5, 0, 4);
    cfg_base   = 32'h1000;
    cfg_stride = 16'd640;
    cfg_width  = 16'd640;
    cfg_height = 16'd480;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_cnt_written", cnt_written, 32'd0);
    check("rst_cnt_clipped", 32'(cnt_clipped), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // RGB565
    lit = '{32'h1504, 32'hF800_0000, 4'b1100};
    send(mk_pix(3, 2, 32'hFFFF_0000), 1'b1, lit, waits);
    drain();

    // ARGB8888
    cfg_fmt = fmt_of(31, 24, 7, 16, 7, 8, 7, 0, 7);
    lit = '{32'h1000, 32'h8012_3456, 4'hF};
    send(mk_pix(0, 0, 32'h8012_3456), 1'b1, lit, waits);
    drain();

    // Clipping: x=-1, x=width, y=height; in_ready must never drop.
    send_model(mk_pix(-1, 0, $urandom));
    check("clip_no_stall_0", 32'(waits), 32'd0);
    send(mk_pix(640, 5, $urandom), 1'b0, lit, waits);
    check("clip_no_stall_1", 32'(waits), 32'd0);
    send(mk_pix(10, 480, $urandom), 1'b0, lit, waits);
    check("clip_no_stall_2", 32'(waits), 32'd0);
    drain();
    check("clip_count", 32'(cnt_clipped), 32'd3);
    check("clip_written", cnt_written, 32'd2);
    check("clip_in_ready", 32'(in_ready), 32'd1);

    // Backpressure: 8 back-to-back pixels, memory stalled for 5 clocks.
    rdy_mode = 2;
    @(posedge clk);
    #1;
    acc0 = acc_count;
    fork
      begin
        for (int i = 0; i < 8; i++) send_model(mk_pix(i, 1, $urandom));
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("bp_accepts", 32'(acc_count - acc0), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        rdy_mode = 0;
      end
    join
    drain();
    check("bp_written", cnt_written, 32'd10);

    // 8-bit RGB332-style format
    cfg_fmt = fmt_of(7, 0, 0, 5, 2, 2, 2, 0, 1);
    lit = '{32'h1004, 32'h0000_FF00, 4'b0010};
    send(mk_pix(5, 0, 32'h00FF_FFFF), 1'b1, lit, waits);
    drain();

    // Randomized configurations and pixels.
    for (int b = 0; b < 6; b++) begin
      cfg_fmt    = fmt_of($urandom_range(31), $urandom_range(31), $urandom_range(7),
                          $urandom_range(31), $urandom_range(7), $urandom_range(31),
                          $urandom_range(7), $urandom_range(31), $urandom_range(7));
      cfg_base   = $urandom & 32'hFFFF_FFFC;
      cfg_stride = 16'($urandom_range(4096, 1));
      cfg_width  = 16'($urandom_range(64, 1));
      cfg_height = 16'($urandom_range(64, 1));
      rdy_mode   = 1;
      for (int i = 0; i < 40; i++)
        send_model(mk_pix(int'($urandom_range(int'(cfg_width) + 7)) - 4,
                          int'($urandom_range(int'(cfg_height) + 7)) - 4, $urandom));
      rdy_mode = 0;
      drain();
    end
    check("rand_written", cnt_written, 32'(exp_written));
    check("rand_clipped", 32'(cnt_clipped), 32'(exp_clipped));

    // Reset with both stages full and memory stalled.
    rdy_mode = 2;
    @(posedge clk);
    #1;
    send_model(mk_pix(1, 1, $urandom));
    send_model(mk_pix(2, 1, $urandom));
    #3;
    rst = 1'b1;
    #1;
    check("midrst_mem_valid", 32'(mem_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cnt_written", cnt_written, 32'd0);
    check("midrst_cnt_clipped", 32'(cnt_clipped), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    exp_written = 0;
    exp_clipped = 0;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    rdy_mode = 0;
    repeat (10) @(posedge clk);
    #1;
    check("postrst_written", cnt_written, 32'd0);
    check("postrst_busy", 32'(busy), 32'd0);

    finish_run();
  end

endmodule
